// File: rtl/ext_ram_ctrl.sv
// Two-port (CNU/VNU) arbiter and zero-fill controller for the single-port extrinsic-message RAM.
// Define EXT_RAM_CTRL_RR_EN for round-robin arbitration; otherwise CNU has fixed priority.
module ext_ram_ctrl #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  v_req,
  input  logic                  v_we,
  input  logic [ADDR_WIDTH-1:0] v_addr,
  input  logic [DATA_WIDTH-1:0] v_wdata,
  output logic                  v_gnt,
  output logic                  v_rvalid,
  output logic [DATA_WIDTH-1:0] v_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_cs,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_busy_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_cs_q, ram_cs_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  s1_vld_q, s1_id_q, s2_vld_q, s2_id_q;
  logic                  rd_gnt;
  logic                  c_rvalid_q, v_rvalid_q;
  logic [DATA_WIDTH-1:0] c_rdata_q, v_rdata_q;
  logic                  v_first;

`ifdef EXT_RAM_CTRL_RR_EN
  logic rr_q, rr_d;

  // Priority only moves on a contested grant, so an idle peer never loses its turn.
  assign v_first = rr_q;
  assign rr_d    = rr_q ^ (c_req & v_req & (c_gnt | v_gnt));

  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  assign v_first = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    c_gnt      = 1'b0;
    v_gnt      = 1'b0;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    case (state_q)
      S_CLEAR: begin
        ram_cs_d   = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = clr_cnt_q;
        ram_din_d  = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = S_RUN;
      end
      S_RUN: begin
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end else begin
          if (c_req && (!v_req || !v_first)) c_gnt = 1'b1;
          else if (v_req)                    v_gnt = 1'b1;
          if (c_gnt) begin
            ram_cs_d   = 1'b1;
            ram_we_d   = c_we;
            ram_addr_d = c_addr;
            ram_din_d  = c_wdata;
          end else if (v_gnt) begin
            ram_cs_d   = 1'b1;
            ram_we_d   = v_we;
            ram_addr_d = v_addr;
            ram_din_d  = v_wdata;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign rd_gnt = (c_gnt & ~c_we) | (v_gnt & ~v_we);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b1;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_din_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_id_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      v_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      v_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_busy_q <= (state_q == S_CLEAR);
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_cs_q   <= ram_cs_d;
      ram_din_q  <= ram_din_d;
      // Owner tag tracks the read through the command and RAM-output cycles (id 1 = VNU).
      s1_vld_q   <= rd_gnt;
      s1_id_q    <= v_gnt;
      s2_vld_q   <= s1_vld_q;
      s2_id_q    <= s1_id_q;
      c_rvalid_q <= s2_vld_q & ~s2_id_q;
      v_rvalid_q <= s2_vld_q & s2_id_q;
      if (s2_vld_q && !s2_id_q) c_rdata_q <= ram_dout;
      if (s2_vld_q && s2_id_q)  v_rdata_q <= ram_dout;
    end
  end

  assign clr_busy = clr_busy_q;
  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;
  assign ram_cs   = ram_cs_q;
  assign ram_din  = ram_din_q;
  assign c_rvalid = c_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign v_rvalid = v_rvalid_q;
  assign v_rdata  = v_rdata_q;

endmodule
